// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared constants and state type for the string-matching engine
// Used by sme_ctrl, shared_memory and the comparator so buffer sizes agree everywhere.
package sme_pkg;

    localparam int STR_MAX = 32;   // string buffer depth in characters
    localparam int PAT_MAX = 8;    // pattern buffer depth in characters
    localparam int STR_AW  = 5;    // character slot address width
    localparam int LEN_W   = 6;    // string length width (0..32)
    localparam int PAT_LW  = 4;    // pattern length width (0..8)

    // Saturation limits at the width of the counters they bound.
    localparam logic [LEN_W-1:0]  STR_MAX_LEN = LEN_W'(STR_MAX);
    localparam logic [PAT_LW-1:0] PAT_MAX_LEN = PAT_LW'(PAT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_STR,
        LOAD_PAT,
        SCAN,
        DONE
    } sme_state_t;

endpackage

// File: rtl/sme_ctrl.sv
// rtl/sme_ctrl.sv - sequencing controller for the string-matching engine
// Ports:
//   clk, reset (async active-low)
//   isstring / ispattern : host character qualifiers (isstring has priority)
//   cmp_hit              : comparator result for cand_idx, same cycle
//   wr_en/wr_sel/wr_addr : combinational memory write port (wr_sel 1 = pattern)
//   str_len / pat_len    : stored lengths
//   cand_idx             : candidate start index under comparison
//   valid/match/match_index : registered result, valid is a one-cycle strobe
module sme_ctrl
    import sme_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              isstring,
    input  logic              ispattern,
    input  logic              cmp_hit,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [STR_AW-1:0] wr_addr,
    output logic [LEN_W-1:0]  str_len,
    output logic [PAT_LW-1:0] pat_len,
    output logic [STR_AW-1:0] cand_idx,
    output logic              valid,
    output logic              match,
    output logic [STR_AW-1:0] match_index
);

    sme_state_t        r_state;
    logic [LEN_W-1:0]  r_str_len;
    logic [PAT_LW-1:0] r_pat_len;
    logic [STR_AW-1:0] r_cand;
    logic              r_valid;
    logic              r_match;
    logic [STR_AW-1:0] r_match_index;

    logic              w_str_char;
    logic              w_pat_char;
    logic              w_accept_new;
    logic [LEN_W-1:0]  w_str_slot;
    logic [PAT_LW-1:0] w_pat_slot;
    logic              w_guard;
    logic [LEN_W-1:0]  w_last;

    // isstring wins when both qualifiers are high.
    assign w_str_char = isstring;
    assign w_pat_char = ispattern & ~isstring;

    // States in which a fresh string or pattern may begin at slot 0.
    assign w_accept_new = (r_state == IDLE) || (r_state == LOAD_STR);

    assign w_str_slot = (r_state == LOAD_STR) ? r_str_len : '0;
    assign w_pat_slot = (r_state == LOAD_PAT) ? r_pat_len : '0;

    // The subtraction is only meaningful once the guard has ruled out pat_len > str_len.
    assign w_guard = ({2'b00, r_pat_len} > r_str_len) || (r_pat_len == '0);
    assign w_last  = r_str_len - {2'b00, r_pat_len};

    always_comb begin
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        if (reset) begin
            if (w_accept_new && w_str_char) begin
                wr_en   = (w_str_slot < STR_MAX_LEN);
                wr_addr = w_str_slot[STR_AW-1:0];
            end else if ((w_accept_new || (r_state == LOAD_PAT)) && w_pat_char) begin
                wr_en   = (w_pat_slot < PAT_MAX_LEN);
                wr_sel  = 1'b1;
                wr_addr = {1'b0, w_pat_slot};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_str_len     <= '0;
            r_pat_len     <= '0;
            r_cand        <= '0;
            r_valid       <= 1'b0;
            r_match       <= 1'b0;
            r_match_index <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_str_char) begin
                        r_str_len <= LEN_W'(1);
                        r_state   <= LOAD_STR;
                    end else if (w_pat_char) begin
                        r_pat_len <= PAT_LW'(1);
                        r_state   <= LOAD_PAT;
                    end
                end
                LOAD_STR: begin
                    if (w_str_char) begin
                        if (r_str_len < STR_MAX_LEN)
                            r_str_len <= r_str_len + LEN_W'(1);
                    end else if (w_pat_char) begin
                        r_pat_len <= PAT_LW'(1);
                        r_state   <= LOAD_PAT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LOAD_PAT: begin
                    if (w_pat_char) begin
                        if (r_pat_len < PAT_MAX_LEN)
                            r_pat_len <= r_pat_len + PAT_LW'(1);
                    end else begin
                        r_cand  <= '0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_guard) begin
                        r_match       <= 1'b0;
                        r_match_index <= '0;
                        r_valid       <= 1'b1;
                        r_state       <= DONE;
                    end else if (cmp_hit) begin
                        r_match       <= 1'b1;
                        r_match_index <= r_cand;
                        r_valid       <= 1'b1;
                        r_state       <= DONE;
                    end else if ({1'b0, r_cand} == w_last) begin
                        r_match       <= 1'b0;
                        r_match_index <= '0;
                        r_valid       <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_cand <= r_cand + STR_AW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign str_len     = r_str_len;
    assign pat_len     = r_pat_len;
    assign cand_idx    = r_cand;
    assign valid       = r_valid;
    assign match       = r_match;
    assign match_index = r_match_index;

endmodule

// File: tb/tb_sme_ctrl.sv
// tb/tb_sme_ctrl.sv - self-checking bench for sme_ctrl with a string-search reference model
module tb_sme_ctrl;

    logic       clk;
    logic       rst_n;
    logic       isstring;
    logic       ispattern;
    logic       cmp_hit;
    logic       wr_en;
    logic       wr_sel;
    logic [4:0] wr_addr;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic [4:0] cand_idx;
    logic       valid;
    logic       match;
    logic [4:0] match_index;

    sme_ctrl dut (
        .clk         (clk),
        .reset       (rst_n),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .cmp_hit     (cmp_hit),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .str_len     (str_len),
        .pat_len     (pat_len),
        .cand_idx    (cand_idx),
        .valid       (valid),
        .match       (match),
        .match_index (match_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stored characters, lengths and loading mode (0 idle, 1 string, 2 pattern).
    byte   m_str [32];
    byte   m_pat [8];
    int    m_slen;
    int    m_plen;
    int    m_mode;
    int    m_match;
    int    m_index;

    // Comparator stand-in: hit_vec[k] says the model pattern occurs at string offset k.
    logic [31:0] hit_vec;
    assign cmp_hit = hit_vec[cand_idx];

    int n_total;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic send(input bit is, input bit ip, input byte ch);
        int slot;
        bit en;
        bit sel;
        @(negedge clk);
        isstring  = is;
        ispattern = ip;
        #1;
        slot = 0;
        en   = 1'b0;
        sel  = 1'b0;
        if (is) begin
            slot = (m_mode == 1) ? m_slen : 0;
            en   = (slot < 32);
        end else if (ip) begin
            slot = (m_mode == 2) ? m_plen : 0;
            en   = (slot < 8);
            sel  = 1'b1;
        end
        chk("wr_en", wr_en, en);
        if (en) begin
            chk("wr_sel", wr_sel, sel);
            chk("wr_addr", wr_addr, slot);
        end
        if (is) begin
            if (en) m_str[slot] = ch;
            m_slen = en ? slot + 1 : 32;
            m_mode = 1;
        end else if (ip) begin
            if (en) m_pat[slot] = ch;
            m_plen = en ? slot + 1 : 8;
            m_mode = 2;
        end else begin
            m_mode = 0;
        end
        @(posedge clk);
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) send(1'b1, 1'b0, s[i]);
    endtask

    task automatic load_pat(input string s);
        for (int i = 0; i < s.len(); i++) send(1'b0, 1'b1, s[i]);
    endtask

    // Plain substring search over the model; returns edges from E0 to the valid cycle.
    task automatic predict(output int lat);
        bit h;
        hit_vec = '0;
        m_match = 0;
        m_index = 0;
        if (m_plen > m_slen || m_plen == 0) begin
            lat = 1;
        end else begin
            lat = m_slen - m_plen + 1;
            for (int k = 0; k <= m_slen - m_plen; k++) begin
                h = 1'b1;
                for (int j = 0; j < m_plen; j++)
                    if (m_str[k + j] != m_pat[j]) h = 1'b0;
                hit_vec[k] = h;
                if (h && m_match == 0) begin
                    m_match = 1;
                    m_index = k;
                    lat     = k + 1;
                end
            end
        end
    endtask

    task automatic run_job(input string tag);
        int exp_lat;
        int n;
        bit seen;
        predict(exp_lat);
        @(negedge clk);
        isstring  = 1'b0;
        ispattern = 1'b0;
        m_mode    = 0;
        @(posedge clk);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid === 1'b1) seen = 1'b1;
        end
        chk($sformatf("%s latency", tag), n, exp_lat);
        chk($sformatf("%s match", tag), match, m_match);
        chk($sformatf("%s match_index", tag), match_index, m_index);
        chk($sformatf("%s str_len", tag), str_len, m_slen);
        chk($sformatf("%s pat_len", tag), pat_len, m_plen);
        @(negedge clk);
        chk($sformatf("%s valid one cycle", tag), valid, 1'b0);
        chk($sformatf("%s match hold", tag), match, m_match);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int vcount;
        int ns;
        int np;
        int st;
        bit reached;
        n_total   = 0;
        n_pass    = 0;
        m_slen    = 0;
        m_plen    = 0;
        m_mode    = 0;
        hit_vec   = '0;
        rst_n     = 1'b0;
        isstring  = 1'b1;
        ispattern = 1'b0;

        // Reset state, with a qualifier held high to show writes are blocked.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset wr_en", wr_en, 1'b0);
        chk("reset valid", valid, 1'b0);
        chk("reset match", match, 1'b0);
        chk("reset match_index", match_index, 0);
        chk("reset str_len", str_len, 0);
        chk("reset pat_len", pat_len, 0);
        chk("reset cand_idx", cand_idx, 0);
        isstring = 1'b0;
        rst_n    = 1'b1;

        load_str("ABCDEFGH");
        load_pat("CDE");
        run_job("abcdefgh_cde");

        load_str("AAAA");
        load_pat("XY");
        run_job("aaaa_xy");

        // Overflow: 40 string chars and 10 pattern chars saturate.
        for (int i = 0; i < 40; i++) send(1'b1, 1'b0, byte'(8'h41 + $urandom_range(0, 1)));
        for (int i = 0; i < 10; i++) send(1'b0, 1'b1, byte'(8'h41 + $urandom_range(0, 1)));
        run_job("overflow");

        // Length guard, then pattern reuse of the old string.
        load_str("AB");
        load_pat("ABC");
        run_job("guard");
        load_pat("B");
        run_job("reuse");

        // Both qualifiers high counts as a string character.
        load_str("AB");
        send(1'b1, 1'b1, byte'(8'h43));
        load_pat("C");
        run_job("both_high");

        // Randomised jobs over a two-letter alphabet so hits are common.
        for (int j = 0; j < 16; j++) begin
            if (j == 0 || $urandom_range(0, 3) != 0) begin
                ns = $urandom_range(1, 34);
                for (int i = 0; i < ns; i++) send(1'b1, 1'b0, byte'(8'h41 + $urandom_range(0, 1)));
            end
            np = $urandom_range(1, 9);
            if ($urandom_range(0, 1) == 1 && np <= 8 && np <= m_slen) begin
                st = $urandom_range(0, m_slen - np);
                for (int i = 0; i < np; i++) send(1'b0, 1'b1, m_str[st + i]);
            end else begin
                for (int i = 0; i < np; i++) send(1'b0, 1'b1, byte'(8'h41 + $urandom_range(0, 1)));
            end
            run_job($sformatf("rand%0d", j));
        end

        // Reset in the middle of a scan.
        load_str("AAAAAAAAAA");
        load_pat("ZZ");
        predict(lat);
        @(negedge clk);
        isstring  = 1'b0;
        ispattern = 1'b0;
        @(posedge clk);
        reached = 1'b0;
        for (int i = 0; i < 12 && !reached; i++) begin
            @(negedge clk);
            if (cand_idx == 5'd3) reached = 1'b1;
        end
        chk("scan reached cand 3", reached, 1'b1);
        rst_n    = 1'b0;
        isstring = 1'b1;
        #1;
        chk("abort wr_en", wr_en, 1'b0);
        chk("abort valid", valid, 1'b0);
        chk("abort match", match, 1'b0);
        chk("abort match_index", match_index, 0);
        chk("abort str_len", str_len, 0);
        chk("abort pat_len", pat_len, 0);
        chk("abort cand_idx", cand_idx, 0);
        m_slen = 0;
        m_plen = 0;
        m_mode = 0;
        @(negedge clk);
        isstring = 1'b0;
        rst_n    = 1'b1;
        vcount   = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid === 1'b1) vcount++;
        end
        chk("no valid after abort", vcount, 0);

        load_pat("A");
        run_job("post_reset_guard");
        load_str("XYA");
        load_pat("A");
        run_job("post_reset_hit");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
